// File: rtl/i2c_write_engine_pkg.sv
// Shared types and constants for the I2C write engine.
//   state_t    : controller states
//   PH_*       : quarter-bit phase indices inside one SCL period
//   NUM_BYTES  : bytes per transfer (address, register, data)
//   tick_div() : CLK cycles per quarter SCL period
package i2c_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, ACK, STOP, DONE} state_t;

  localparam logic [1:0] PH_SETUP = 2'd0;  // SCL low, SDA changes here
  localparam logic [1:0] PH_RISE  = 2'd1;  // SCL goes high
  localparam logic [1:0] PH_HIGH  = 2'd2;  // SCL high, SDA stable / sampled
  localparam logic [1:0] PH_FALL  = 2'd3;  // SCL goes low

  localparam int NUM_BYTES = 3;

  function automatic int tick_div(input int clk_freq, input int i2c_freq);
    return clk_freq / (4 * i2c_freq);
  endfunction

endpackage

// File: rtl/i2c_write_engine_tick_gen.sv
// Quarter-bit clock-enable generator.
//   CLK, RST : system clock, async active-low reset
//   clr      : synchronous restart; first tick follows DIV cycles later
//   tick     : one-CLK enable pulse every DIV cycles
module i2c_tick_gen #(
  parameter int DIV = 625
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(DIV - 1));
  assign tick = wrap && !clr;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)              cnt <= '0;
    else if (clr || wrap)  cnt <= '0;
    else                   cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/i2c_write_engine.sv
// Open-drain I2C master write serializer: START, three MSB-first bytes
// each followed by an ACK slot, STOP. A NACK aborts to STOP early.
//   CLK, RST   : system clock, async active-low reset
//   i2c_data   : {address+R/W, register, data}, sampled at acceptance
//   go         : level request; done holds until go falls
//   done       : transfer finished
//   ack_err    : a NACK was seen (valid while done)
//   busy       : from acceptance until back in IDLE
//   I2C_SCLK   : SCL, push-pull
//   I2C_SDAT   : SDA, drives 0 or Z only
// TICK_DIV must be at least 2.
module i2c_write_engine
  import i2c_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int I2C_FREQ = 20000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [23:0] i2c_data,
  input  logic        go,
  output logic        done,
  output logic        ack_err,
  output logic        busy,
  output logic        I2C_SCLK,
  inout  wire         I2C_SDAT
);

  localparam int TICK_DIV = tick_div(CLK_FREQ, I2C_FREQ);

  state_t      state, state_n;
  logic [1:0]  ph, ph_n;
  logic [2:0]  bit_cnt, bit_n;
  logic [1:0]  byte_cnt, byte_n;
  logic [23:0] sh, sh_n;
  logic        scl, scl_n;
  logic        sda_oe, oe_n;
  logic        aerr_n;
  logic        tick, tick_clr;

  i2c_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (tick_clr),
    .tick (tick)
  );

  assign I2C_SCLK = scl;
  assign I2C_SDAT = sda_oe ? 1'b0 : 1'bz;
  assign done     = (state == DONE);
  assign busy     = (state != IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      ph       <= PH_SETUP;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      sh       <= '0;
      scl      <= 1'b1;
      sda_oe   <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      state    <= state_n;
      ph       <= ph_n;
      bit_cnt  <= bit_n;
      byte_cnt <= byte_n;
      sh       <= sh_n;
      scl      <= scl_n;
      sda_oe   <= oe_n;
      ack_err  <= aerr_n;
    end
  end

  always_comb begin
    state_n  = state;
    ph_n     = ph;
    bit_n    = bit_cnt;
    byte_n   = byte_cnt;
    sh_n     = sh;
    scl_n    = scl;
    oe_n     = sda_oe;
    aerr_n   = ack_err;
    tick_clr = 1'b0;
    case (state)
      IDLE: begin
        scl_n = 1'b1;
        oe_n  = 1'b0;
        if (go && !done) begin
          sh_n     = i2c_data;
          aerr_n   = 1'b0;
          ph_n     = PH_SETUP;
          bit_n    = '0;
          byte_n   = '0;
          tick_clr = 1'b1;
          state_n  = START;
        end
      end
      START: if (tick) begin
        if (ph == PH_SETUP) begin
          oe_n = 1'b1;               // SDA falls with SCL high
          ph_n = PH_RISE;
        end else begin
          scl_n   = 1'b0;
          ph_n    = PH_SETUP;
          state_n = DATA;
        end
      end
      DATA: if (tick) begin
        ph_n = ph + 2'd1;
        case (ph)
          PH_SETUP: oe_n  = !sh[23];
          PH_RISE:  scl_n = 1'b1;
          PH_HIGH:  ;
          default: begin
            scl_n = 1'b0;
            sh_n  = {sh[22:0], 1'b0};
            bit_n = bit_cnt + 3'd1;  // 7 wraps to 0 entering the ACK slot
            if (bit_cnt == 3'd7) state_n = ACK;
          end
        endcase
      end
      ACK: if (tick) begin
        ph_n = ph + 2'd1;
        case (ph)
          PH_SETUP: oe_n  = 1'b0;
          PH_RISE:  scl_n = 1'b1;
          // anything but a driven low (released bus included) is a NACK
          PH_HIGH:  if (I2C_SDAT == 1'b0) aerr_n = ack_err; else aerr_n = 1'b1;
          default: begin
            scl_n = 1'b0;
            if (ack_err || byte_cnt == 2'(NUM_BYTES - 1)) state_n = STOP;
            else begin
              byte_n  = byte_cnt + 2'd1;
              state_n = DATA;
            end
          end
        endcase
      end
      STOP: begin
        // PH_FALL is a one-CLK settle after SDA release before DONE
        if (ph == PH_FALL) state_n = DONE;
        else if (tick) begin
          ph_n = ph + 2'd1;
          case (ph)
            PH_SETUP: oe_n  = 1'b1;
            PH_RISE:  scl_n = 1'b1;
            default:  oe_n  = 1'b0;  // SDA rises with SCL high
          endcase
        end
      end
      DONE: if (!go) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule
